// File: rtl/agc_overload_detector.sv
// agc_overload_detector
//   Measures |amplified_signal| over fixed windows of valid samples and produces
//   the registered overload decision consumed by the AGC gain-stepping loop.
//   After reset or a gain_change pulse the block blanks for SETTLE_CYCLES cycles
//   while the VGA chain settles, then measures back-to-back windows.
//
// Optional build macro: OVLD_HYST_EN
//   When defined, an asserted overload is only released once the window peak
//   drops below (threshold - HYST), saturating at 0.
//
// Ports:
//   clk              in   single clock
//   RESETn           in   asynchronous active-low reset
//   amplified_signal in   16-bit signed sample
//   sample_valid     in   sample accepted on this edge
//   threshold        in   16-bit unsigned magnitude threshold (quasi-static)
//   gain_change      in   one-cycle pulse when the VGA gain was updated
//   overload         out  registered overload decision, held between decisions
//   window_done      out  one-cycle pulse when a decision is written
//   peak_out         out  peak magnitude of the last completed window
module agc_overload_detector #(
  parameter int unsigned WINDOW_LEN    = 16,
  parameter int unsigned HIT_MIN       = 2,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned HYST          = 256
) (
  input  logic        clk,
  input  logic        RESETn,
  input  logic [15:0] amplified_signal,
  input  logic        sample_valid,
  input  logic [15:0] threshold,
  input  logic        gain_change,
  output logic        overload,
  output logic        window_done,
  output logic [15:0] peak_out
);

  localparam int unsigned    CntW    = $clog2(WINDOW_LEN + 1);
  localparam logic [CntW-1:0] WinC    = CntW'(WINDOW_LEN);
  localparam logic [CntW-1:0] HitMinC = CntW'(HIT_MIN);
  localparam logic [CntW-1:0] OneC    = CntW'(1);
  localparam logic [7:0]      SettleC = 8'(SETTLE_CYCLES);
  localparam logic [15:0]     HystC   = 16'(HYST);
`ifdef OVLD_HYST_EN
  localparam logic            HystEn  = 1'b1;
`else
  localparam logic            HystEn  = 1'b0;
`endif

  typedef enum logic [1:0] {StSettle, StMeasure, StReport} state_t;

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_settle_cnt, w_settle_nxt;
  logic [CntW-1:0]   r_sample_cnt, w_sample_nxt;
  logic [CntW-1:0]   r_hit_cnt, w_hit_nxt;
  logic [15:0]       r_peak, w_peak_nxt;
  logic [15:0]       r_mag;
  logic              r_mag_vld;
  logic              r_overload, w_overload_nxt;
  logic              r_window_done, w_window_done_nxt;
  logic [15:0]       r_peak_out, w_peak_out_nxt;

  logic [15:0]       w_mag;
  logic              w_hit;
  logic [15:0]       w_rel_thr;
  logic              w_decision;
  logic [CntW-1:0]   w_sample_inc;

  // -32768 has no positive counterpart; clamp it to the largest magnitude.
  always_comb begin
    if (!amplified_signal[15]) begin
      w_mag = amplified_signal;
    end else if (amplified_signal == 16'h8000) begin
      w_mag = 16'h7fff;
    end else begin
      w_mag = 16'(-amplified_signal);
    end
  end

  assign w_hit        = (r_mag >= threshold);
  assign w_rel_thr    = (threshold > HystC) ? (threshold - HystC) : 16'h0000;
  assign w_sample_inc = r_sample_cnt + OneC;

  // Hold an asserted overload while the peak has not fallen below the release level.
  assign w_decision = (r_hit_cnt >= HitMinC) ||
                      (HystEn && r_overload && (r_peak >= w_rel_thr));

  always_comb begin
    w_state_nxt       = r_state;
    w_settle_nxt      = r_settle_cnt;
    w_sample_nxt      = r_sample_cnt;
    w_hit_nxt         = r_hit_cnt;
    w_peak_nxt        = r_peak;
    w_overload_nxt    = r_overload;
    w_peak_out_nxt    = r_peak_out;
    w_window_done_nxt = 1'b0;

    if (gain_change) begin
      w_state_nxt  = StSettle;
      w_settle_nxt = SettleC;
      w_sample_nxt = '0;
      w_hit_nxt    = '0;
      w_peak_nxt   = '0;
    end else begin
      unique case (r_state)
        StSettle: begin
          if (r_settle_cnt == 8'd0) begin
            w_state_nxt = StMeasure;
          end else begin
            w_settle_nxt = r_settle_cnt - 8'd1;
          end
        end
        StMeasure: begin
          if (r_mag_vld) begin
            w_sample_nxt = w_sample_inc;
            if (r_mag > r_peak) w_peak_nxt = r_mag;
            if (w_hit && (r_hit_cnt != WinC)) w_hit_nxt = r_hit_cnt + OneC;
            if (w_sample_inc == WinC) w_state_nxt = StReport;
          end
        end
        StReport: begin
          w_overload_nxt    = w_decision;
          w_peak_out_nxt    = r_peak;
          w_window_done_nxt = 1'b1;
          // A sample arriving now opens the next window rather than being lost.
          w_sample_nxt      = r_mag_vld ? OneC : '0;
          w_hit_nxt         = (r_mag_vld && w_hit) ? OneC : '0;
          w_peak_nxt        = r_mag_vld ? r_mag : 16'h0000;
          w_state_nxt       = StMeasure;
        end
        default: begin
          w_state_nxt  = StSettle;
          w_settle_nxt = SettleC;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_state       <= StSettle;
      r_settle_cnt  <= SettleC;
      r_sample_cnt  <= '0;
      r_hit_cnt     <= '0;
      r_peak        <= '0;
      r_mag         <= '0;
      r_mag_vld     <= 1'b0;
      r_overload    <= 1'b0;
      r_window_done <= 1'b0;
      r_peak_out    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_settle_cnt  <= w_settle_nxt;
      r_sample_cnt  <= w_sample_nxt;
      r_hit_cnt     <= w_hit_nxt;
      r_peak        <= w_peak_nxt;
      r_mag         <= w_mag;
      // The in-flight magnitude is dropped when the gain changes.
      r_mag_vld     <= sample_valid && !gain_change;
      r_overload    <= w_overload_nxt;
      r_window_done <= w_window_done_nxt;
      r_peak_out    <= w_peak_out_nxt;
    end
  end

  assign overload    = r_overload;
  assign window_done = r_window_done;
  assign peak_out    = r_peak_out;

endmodule

// File: tb/tb_agc_overload_detector.sv
// Directed testbench for agc_overload_detector with default parameters.
module tb_agc_overload_detector;

  logic        clk = 1'b0;
  logic        RESETn;
  logic [15:0] amplified_signal;
  logic        sample_valid;
  logic [15:0] threshold;
  logic        gain_change;
  logic        overload;
  logic        window_done;
  logic [15:0] peak_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  agc_overload_detector dut (
    .clk              (clk),
    .RESETn           (RESETn),
    .amplified_signal (amplified_signal),
    .sample_valid     (sample_valid),
    .threshold        (threshold),
    .gain_change      (gain_change),
    .overload         (overload),
    .window_done      (window_done),
    .peak_out         (peak_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic restart;
    gain_change  = 1'b1;
    sample_valid = 1'b0;
    tick;
    gain_change  = 1'b0;
    repeat (12) tick;
  endtask

  // 16 consecutive valid samples: first nhit are hv, the rest ov.
  task automatic send_win(input string tag, input int nhit, input logic [15:0] hv,
                          input logic [15:0] ov, input logic exp_ovl,
                          input logic [15:0] exp_peak);
    for (int i = 0; i < 16; i++) begin
      amplified_signal = (i < nhit) ? hv : ov;
      sample_valid     = 1'b1;
      tick;
    end
    sample_valid     = 1'b0;
    amplified_signal = 16'h0000;
    tick;
    check_eq({tag, " done@N+1"}, 32'(window_done), 32'd0);
    tick;
    check_eq({tag, " done@N+2"}, 32'(window_done), 32'd1);
    check_eq({tag, " overload"}, 32'(overload), 32'(exp_ovl));
    check_eq({tag, " peak"}, 32'(peak_out), 32'(exp_peak));
    tick;
    check_eq({tag, " done@N+3"}, 32'(window_done), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first;
    int dones;
    logic exp_hyst;

    RESETn           = 1'b0;
    amplified_signal = 16'h0000;
    sample_valid     = 1'b1;
    threshold        = 16'd1000;
    gain_change      = 1'b0;
    repeat (3) tick;
    check_eq("reset overload", 32'(overload), 32'd0);
    check_eq("reset peak", 32'(peak_out), 32'd0);
    check_eq("reset done", 32'(window_done), 32'd0);

    // First decision after release: 8 settle + 16 samples + 2.
    RESETn = 1'b1;
    first  = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      tick;
      if (window_done) first = k;
    end
    check_eq("first done latency", 32'(first), 32'd26);
    check_eq("first overload", 32'(overload), 32'd0);
    check_eq("first peak", 32'(peak_out), 32'd0);

    restart;
    send_win("two hits", 2, 16'hf830, 16'd100, 1'b1, 16'd2000);
    send_win("one hit", 1, 16'hf830, 16'd100, 1'b0, 16'd2000);

    // Saturation of -32768
    threshold = 16'd32767;
    send_win("sat hit", 2, 16'h8000, 16'd0, 1'b1, 16'd32767);
    send_win("below sat", 2, 16'd32766, 16'd0, 1'b0, 16'd32766);
    threshold = 16'd1000;

    // Abort at sample 10 of a window with 5 hits; hits during settle must be dropped.
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      amplified_signal = (i < 5) ? 16'hf830 : 16'd100;
      sample_valid     = 1'b1;
      gain_change      = (i == 9);
      tick;
      if (window_done) dones++;
    end
    gain_change = 1'b0;
    for (int i = 0; i < 4; i++) begin
      amplified_signal = 16'hf830;
      tick;
      if (window_done) dones++;
    end
    sample_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick;
      if (window_done) dones++;
    end
    check_eq("abort no done", 32'(dones), 32'd0);
    check_eq("abort overload held", 32'(overload), 32'd0);
    check_eq("abort peak held", 32'(peak_out), 32'd32766);
    send_win("after abort", 0, 16'h0000, 16'd300, 1'b0, 16'd300);

    // gain_change on the REPORT cycle
    send_win("pre sim", 2, 16'hf830, 16'd100, 1'b1, 16'd2000);
    for (int i = 0; i < 16; i++) begin
      amplified_signal = 16'd50;
      sample_valid     = 1'b1;
      tick;
    end
    sample_valid = 1'b0;
    tick;
    check_eq("sim done@N+1", 32'(window_done), 32'd0);
    gain_change = 1'b1;
    tick;
    gain_change = 1'b0;
    check_eq("sim done@N+2", 32'(window_done), 32'd0);
    check_eq("sim overload held", 32'(overload), 32'd1);
    check_eq("sim peak held", 32'(peak_out), 32'd2000);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (window_done) dones++;
    end
    check_eq("sim no later done", 32'(dones), 32'd0);

    // Continuous stream: sample 16 lands on the REPORT cycle and opens window 2.
    for (int i = 0; i < 32; i++) begin
      amplified_signal = (i == 16 || i == 17) ? 16'hf830 : 16'd100;
      sample_valid     = 1'b1;
      tick;
      if (i == 16) check_eq("stream w1 done@N+1", 32'(window_done), 32'd0);
      if (i == 17) begin
        check_eq("stream w1 done", 32'(window_done), 32'd1);
        check_eq("stream w1 overload", 32'(overload), 32'd0);
        check_eq("stream w1 peak", 32'(peak_out), 32'd100);
      end
    end
    sample_valid = 1'b0;
    tick;
    check_eq("stream w2 done@N+1", 32'(window_done), 32'd0);
    tick;
    check_eq("stream w2 done", 32'(window_done), 32'd1);
    check_eq("stream w2 overload", 32'(overload), 32'd1);
    check_eq("stream w2 peak", 32'(peak_out), 32'd2000);
    tick;

    // Release behaviour: threshold 1000, HYST 256 -> release below 744.
`ifdef OVLD_HYST_EN
    exp_hyst = 1'b1;
`else
    exp_hyst = 1'b0;
`endif
    send_win("hyst set", 2, 16'hf830, 16'd100, 1'b1, 16'd2000);
    send_win("hyst peak900", 0, 16'h0000, 16'd900, exp_hyst, 16'd900);
    send_win("hyst peak700", 0, 16'h0000, 16'd700, 1'b0, 16'd700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
